// File: rtl/ebpf_shift_pkg.sv
// Shared definitions for the eBPF shift pipeline: op encoding, default width and
// helpers that spread the binary shift steps across pipeline stages.
package ebpf_shift_pkg;

    typedef enum logic [1:0] {
        OpLsh  = 2'b00,
        OpRsh  = 2'b01,
        OpArsh = 2'b10,
        OpRsv  = 2'b11
    } shift_op_e;

    localparam int unsigned DefaultDataW = 64;

    // Earlier stages absorb the remainder when steps do not divide evenly.
    function automatic int unsigned stage_step_count(input int unsigned n_steps,
                                                     input int unsigned n_stages,
                                                     input int unsigned k);
        return n_steps / n_stages + ((k < (n_steps % n_stages)) ? 1 : 0);
    endfunction

    function automatic int unsigned stage_step_first(input int unsigned n_steps,
                                                     input int unsigned n_stages,
                                                     input int unsigned k);
        int unsigned base;
        int unsigned extra;
        base  = n_steps / n_stages;
        extra = n_steps % n_stages;
        return k * base + ((k < extra) ? k : extra);
    endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Valid/ready bus for the shift pipeline: operation in, result out.
interface shift_unit_pipe_if #(
    parameter int unsigned DATA_W = ebpf_shift_pkg::DefaultDataW,
    parameter int unsigned TAG_W  = 4
);
    import ebpf_shift_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    shift_op_e         in_op;
    logic              in_alu32;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_c;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, in_alu32, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_alu32, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_tag, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// One pipeline stage: applies its share of the binary shift steps and registers
// the result together with the operation's sideband.
module shift_stage
    import ebpf_shift_pkg::*;
#(
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned AMT_W   = 6,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned STEP_LO = 0,
    parameter int unsigned STEP_N  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_val,
    input  logic [AMT_W-1:0]  up_amt,
    input  shift_op_e         up_op,
    input  logic              up_alu32,
    input  logic              up_err,
    input  logic [TAG_W-1:0]  up_tag,
    input  logic              dn_load,
    output logic              load,
    output logic              valid,
    output logic [DATA_W-1:0] val,
    output logic [AMT_W-1:0]  amt,
    output shift_op_e         op,
    output logic              alu32,
    output logic              err,
    output logic [TAG_W-1:0]  tag
);

    logic [DATA_W-1:0] chain [STEP_N+1];

    logic              valid_q;
    logic [DATA_W-1:0] val_q;
    logic [AMT_W-1:0]  amt_q;
    shift_op_e         op_q;
    logic              alu32_q;
    logic              err_q;
    logic [TAG_W-1:0]  tag_q;

    assign chain[0] = up_val;

    // ARSH fill comes from the MSB; 32-bit ARSH operands arrive already sign-extended.
    for (genvar i = 0; i < STEP_N; i++) begin : g_step
        localparam int unsigned Dist = 2 ** (STEP_LO + i);
        assign chain[i+1] = !up_amt[STEP_LO + i] ? chain[i] :
                            (up_op == OpLsh)     ? chain[i] << Dist :
                            (up_op == OpArsh)    ? $unsigned($signed(chain[i]) >>> Dist) :
                                                   chain[i] >> Dist;
    end

    assign load = !valid_q || dn_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            val_q   <= '0;
            amt_q   <= '0;
            op_q    <= OpLsh;
            alu32_q <= 1'b0;
            err_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            if (load) begin
                valid_q <= up_valid;
            end
            if (load && up_valid) begin
                val_q   <= chain[STEP_N];
                amt_q   <= up_amt;
                op_q    <= up_op;
                alu32_q <= up_alu32;
                err_q   <= up_err;
                tag_q   <= up_tag;
            end
        end
    end

    assign valid = valid_q;
    assign val   = val_q;
    assign amt   = amt_q;
    assign op    = op_q;
    assign alu32 = alu32_q;
    assign err   = err_q;
    assign tag   = tag_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined eBPF LSH/RSH/ARSH unit with 32/64-bit ALU classes, valid/ready on both
// sides and collapsing bubbles.
module shift_unit_pipe
    import ebpf_shift_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input logic             clk,
    input logic             rst,
    shift_unit_pipe_if.slave bus
);

    localparam int unsigned AMT_W     = $clog2(DATA_W);
    localparam int unsigned NUM_STEPS = AMT_W;

    localparam logic [AMT_W-1:0]  Amt32Mask = AMT_W'(31);
    localparam logic [DATA_W-1:0] Lo32Mask  = DATA_W'(32'hFFFF_FFFF);

    // Index 0 is the preprocessed input; index k+1 is the register of stage k.
    logic              s_valid [STAGES+1];
    logic              s_load  [STAGES+1];
    logic [DATA_W-1:0] s_val   [STAGES+1];
    logic [AMT_W-1:0]  s_amt   [STAGES+1];
    shift_op_e         s_op    [STAGES+1];
    logic              s_alu32 [STAGES+1];
    logic              s_err   [STAGES+1];
    logic [TAG_W-1:0]  s_tag   [STAGES+1];

    logic              pre_err;
    logic [DATA_W-1:0] pre_val;
    logic              unused_b_hi;

    assign unused_b_hi = ^bus.in_b[DATA_W-1:AMT_W];

    assign pre_err = (bus.in_op == OpRsv);

    // 32-bit class: zero-extend, except ARSH which sign-extends so the shared
    // arithmetic shift fills with bit 31; the output mask restores zero-extension.
    always_comb begin
        pre_val = bus.in_a;
        if (pre_err) begin
            pre_val = '0;
        end else if (bus.in_alu32) begin
            if (bus.in_op == OpArsh) begin
                pre_val = DATA_W'($signed(bus.in_a[31:0]));
            end else begin
                pre_val = DATA_W'(bus.in_a[31:0]);
            end
        end
    end

    assign s_valid[0] = bus.in_valid;
    assign s_val[0]   = pre_val;
    assign s_amt[0]   = bus.in_alu32 ? (bus.in_b[AMT_W-1:0] & Amt32Mask) : bus.in_b[AMT_W-1:0];
    assign s_op[0]    = bus.in_op;
    assign s_alu32[0] = bus.in_alu32;
    assign s_err[0]   = pre_err;
    assign s_tag[0]   = bus.in_tag;

    assign s_load[STAGES] = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned StepLo = stage_step_first(NUM_STEPS, STAGES, k);
        localparam int unsigned StepN  = stage_step_count(NUM_STEPS, STAGES, k);

        shift_stage #(
            .DATA_W  (DATA_W),
            .AMT_W   (AMT_W),
            .TAG_W   (TAG_W),
            .STEP_LO (StepLo),
            .STEP_N  (StepN)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (s_valid[k]),
            .up_val   (s_val[k]),
            .up_amt   (s_amt[k]),
            .up_op    (s_op[k]),
            .up_alu32 (s_alu32[k]),
            .up_err   (s_err[k]),
            .up_tag   (s_tag[k]),
            .dn_load  (s_load[k+1]),
            .load     (s_load[k]),
            .valid    (s_valid[k+1]),
            .val      (s_val[k+1]),
            .amt      (s_amt[k+1]),
            .op       (s_op[k+1]),
            .alu32    (s_alu32[k+1]),
            .err      (s_err[k+1]),
            .tag      (s_tag[k+1])
        );
    end

    assign bus.in_ready  = s_load[0];
    assign bus.out_valid = s_valid[STAGES];
    assign bus.out_c     = s_alu32[STAGES] ? (s_val[STAGES] & Lo32Mask) : s_val[STAGES];
    assign bus.out_tag   = s_tag[STAGES];
    assign bus.out_err   = s_err[STAGES];

endmodule

// File: doc/shift_unit_pipe.md
SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 Parameter DATA_W, default 64: operand/result width; SHALL be 64 or 32.
REQ-002 Parameter STAGES, default 3: pipeline register stages; SHALL be 1..log2(DATA_W).
REQ-003 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  an operation is presented.
REQ-007 in_ready  output  1  the block accepts the operation this cycle.
REQ-008 in_a  input  DATA_W  value to be shifted.
REQ-009 in_b  input  DATA_W  shift amount source (low bits used only).
REQ-010 in_op  input  2  00 LSH, 01 RSH (logical), 10 ARSH (arithmetic), 11 reserved.
REQ-011 in_alu32  input  1  1 = eBPF 32-bit ALU class; 0 = 64-bit class.
REQ-012 in_tag  input  TAG_W  opaque sideband, returned unchanged with the result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 out_c  output  DATA_W  shift result.
REQ-016 out_tag  output  TAG_W  tag of the operation producing out_c.
REQ-017 out_err  output  1  operation used reserved op 11.

Function
REQ-018 Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-019 Shift amount: in_b[5:0] when in_alu32=0; in_b[4:0] when in_alu32=1; higher bits ignored (no oversize shift possible).
REQ-020 alu32=1: operand is in_a[31:0]; ARSH sign is bit 31; result zero-extended to DATA_W.
REQ-021 alu32=0: full DATA_W operand; ARSH sign is bit DATA_W-1.
REQ-022 Op 11: out_c = 0, out_err = 1; the op still occupies a pipeline slot and preserves ordering.
REQ-023 Shift decomposed into log2(DATA_W) binary steps (1,2,4,...), distributed as evenly as possible over STAGES registered stages, earliest stages taking the extra step.
REQ-024 Latency: exactly STAGES cycles from input transfer to out_valid with no back-pressure.
REQ-025 Throughput: one operation per cycle while out_ready=1.
REQ-026 Each stage holds a valid bit; stage k loads when empty or when stage k+1 loads in the same cycle (bubbles collapse).
REQ-027 in_ready = stage-0 can load; SHALL be combinationally independent of in_valid.
REQ-028 out_valid with out_ready=0: out_c, out_tag and out_err SHALL hold stable until transfer.
REQ-029 Full pipe with out_ready=0: in_ready=0 and no state changes.
REQ-030 Full pipe with out_ready=1 and in_valid=1: simultaneous output and input transfer, in_ready=1.
REQ-031 Results SHALL leave in acceptance order; no operation dropped or duplicated.

Reset
REQ-032 rst asserted: all stage valid bits clear immediately; out_valid=0, out_err=0, out_c=0, out_tag=0.
REQ-033 in_ready SHALL be 1 during reset and from the first cycle after deassertion.
REQ-034 Reset mid-operation discards all in-flight operations; none appear after deassertion.

Structure
REQ-035 Shared package ebpf_shift_pkg holds the op enum (LSH, RSH, ARSH, RSV) and default DATA_W.
REQ-036 One sub-module shift_stage: one pipeline register plus its subset of shift steps and valid/handshake logic, instantiated STAGES times via generate.

Verification
REQ-038 a=0x8000_0000_0000_0001, b=1, RSH, alu32=0 -> out_c=0x4000_0000_0000_0000 after 3 cycles.
REQ-039 same a, b=0x41, ARSH, alu32=0 -> shift 1, out_c=0xC000_0000_0000_0000.
REQ-040 a=0xFFFF_FFFF_8000_0000, b=4, ARSH, alu32=1 -> out_c=0x0000_0000_F800_0000; b=36 gives same result.
REQ-041 a=1, b=63, LSH -> 0x8000_0000_0000_0000; op 11 -> out_c=0, out_err=1, tag preserved.
REQ-042 100 random ops, random in_valid/out_ready -> results match model, in order, tags intact, outputs stable while stalled.
REQ-043 rst asserted with 3 ops in flight -> out_valid=0 at once; no stale result after release; in_ready=1.
